spart_rx: RTL and testbench
===========================

# spart_rx

Serial receive stage of the SPART: oversamples the asynchronous RxD line, assembles 8N1 frames into a byte, and presents that byte and its ready flag to the SPART bus interface. `rbuffer` and `rda` drive the bus interface's receive-buffer and status inputs. `rda` is cleared when the processor reads the receive buffer over the bus.

## Interface
- `OVERSAMPLE`, default 16: baud-enable ticks per bit period; must be a power of two.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: one-`clk`-wide baud tick from the baud generator, at `OVERSAMPLE` × baud rate.
- `rxd` input 1: asynchronous serial line; idle high.
- `iocs` input 1: SPART chip select.
- `iorw` input 1: 1 = processor read, 0 = processor write.
- `ioaddr` input 2: register address; 2'b00 is the receive buffer.
- `rbuffer` output 8: last correctly framed byte received.
- `rda` output 1: receive data available.
- `frame_err` output 1: sticky framing error flag.

## Operation
- `rxd` passes through a two-flop synchronizer, reset to 1. All logic below uses the synchronized value, `rxd_s`.
- FSM states are IDLE, START, DATA, STOP and BREAK. A 4-bit tick counter `cnt` and a 3-bit bit index `bidx` count within the frame.
- **IDLE:**
  - `rxd_s` = 0 → go to START, `cnt` = 0. No `enable` is needed for this transition.
- **START:** `cnt` increments on each `enable`.
  - At the tick where `cnt` == 7 (mid start bit), `rxd_s` = 0 → go to DATA, `cnt` = 0, `bidx` = 0.
  - At the same tick, `rxd_s` = 1 → glitch; return to IDLE.
- **DATA:** `cnt` increments on each `enable`.
  - At the tick where `cnt` == 15, shift right with `shreg[7]` ← `rxd_s`, then `bidx`++.
  - After the shift with `bidx` == 7 → go to STOP, `cnt` = 0.
- **STOP:** at the tick where `cnt` == 15:
  - `rxd_s` = 1 → `rbuffer` ← `shreg`, `rda` ← 1; go to IDLE.
  - `rxd_s` = 0 → `frame_err` ← 1, `rbuffer` and `rda` unchanged; go to BREAK.
- **BREAK:** wait for `rxd_s` = 1, then go to IDLE. A held-low line never produces a spurious frame.
- **Read-clear:** `iocs & iorw & (ioaddr == 2'b00)` in a cycle clears `rda` at the next edge.
  - `frame_err` clears on any read with `ioaddr` == 2'b01 (status read).
- **Overrun:** a new byte overwrites `rbuffer`; `rda` stays 1; there is no overrun flag.
- **Simultaneous set and clear:** if `rda` set and read-clear occur in the same cycle, set wins and `rda` = 1.
- **Writes:** bus writes have no effect on this block.

## Timing
- **Reset values:** `rbuffer` = 8'h00, `rda` = 0, `frame_err` = 0, state = IDLE, `cnt` = 0, `bidx` = 0, `shreg` = 8'h00, synchronizer = 2'b11.
- **Reset mid-frame:** reset aborts the frame immediately. After release, the FSM starts in IDLE.
- **Input latency:** 2 `clk` from an `rxd` edge to `rxd_s`.
- **Sampling points:** the start bit is checked 8 ticks after the falling edge is detected. Each data bit is sampled 16 ticks after the previous sample point, i.e. mid-bit.
- **Output latency:** `rbuffer` and `rda` update on the `clk` edge of the stop-bit sample tick. That edge is 8 + 16·9 = 152 ticks after start detection.
- **Read-clear latency:** `rda` falls one `clk` after the qualifying read cycle.
- **`enable` gating:** `enable` low freezes `cnt` and the FSM, except the IDLE start detect and the BREAK exit.

## Structure
- Shared package `spart_pkg` holds:
  - the `rx_state_t` enum {IDLE, START, DATA, STOP, BREAK};
  - localparams `ADDR_RXBUF` = 2'b00 and `ADDR_STATUS` = 2'b01;
  - `OVERSAMPLE`-derived constants `HALF_BIT` = 7 and `FULL_BIT` = 15.
- One sub-module: `spart_sync`, a two-flop synchronizer with reset value 1. The same module is reusable by the transmitter.

## Test plan
- **Single byte:** send 8'hA5 at 16 ticks/bit → `rda` rises 152 ticks after the start edge; `rbuffer` = 8'hA5; `frame_err` = 0.
- **Read-clear:** after the byte above, drive `iocs`=1, `iorw`=1, `ioaddr`=00 for one cycle → `rda` = 0 the next cycle; `rbuffer` holds 8'hA5.
- **Start glitch:** pull `rxd` low for 4 ticks, then high → FSM back to IDLE; `rda` = 0; a following 8'h3C frame is received correctly.
- **Framing error:** send 8'h5A with stop bit = 0, then hold the line low for 40 ticks → `frame_err` = 1; `rda` = 0; no frame received until the line returns high. The next frame 8'h11 is received.
- **Overrun and collision:** send 8'h01 then 8'h02 with no read → `rbuffer` = 8'h02 and `rda` = 1. Then read-clear on the exact stop-sample cycle of a third byte 8'h03 → `rda` = 1 and `rbuffer` = 8'h03.
- **Reset mid-frame:** assert `rst_n` = 0 during data bit 4 → all outputs return to their reset values asynchronously. A full frame 8'hFF after release is received.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state type, bus register map and
// oversampling-derived tick constants.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [1:0] ADDR_RXBUF  = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Tick index of the mid-bit and end-of-bit points for a given oversample rate.
  function automatic int unsigned half_bit(input int unsigned os);
    return os / 2 - 1;
  endfunction

  function automatic int unsigned full_bit(input int unsigned os);
    return os - 1;
  endfunction

  localparam int unsigned HALF_BIT = OVERSAMPLE_DEF / 2 - 1;
  localparam int unsigned FULL_BIT = OVERSAMPLE_DEF - 1;

endpackage

// File: rtl/spart_sync.sv
// Two-flop synchronizer for asynchronous SPART serial lines; resets to idle-high.
module spart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_q;
  logic [1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'b11;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[1];

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: oversampled 8N1 deframer feeding the bus interface
// receive buffer, data-available and sticky framing-error flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rbuffer,
  output logic                 rda,
  output logic                 frame_err
);

  localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(half_bit(OVERSAMPLE));
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(full_bit(OVERSAMPLE));
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rbuffer_q, rbuffer_d;
  logic                 rda_q, rda_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rda_set, ferr_set;
  logic                 rd_rxbuf, rd_status;

  spart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign rd_rxbuf  = iocs & iorw & (ioaddr == ADDR_RXBUF);
  assign rd_status = iocs & iorw & (ioaddr == ADDR_STATUS);

  // Frame FSM; only start detect and break exit run without a baud tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    rbuffer_d = rbuffer_q;
    rda_set   = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (enable) begin
          if (cnt_q == HALF_CNT) begin
            if (!rxd_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (enable) begin
          if (cnt_q == FULL_CNT) begin
            cnt_d   = '0;
            shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
            bidx_d  = bidx_q + BIDX_W'(1);
            if (bidx_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (enable) begin
          if (cnt_q == FULL_CNT) begin
            if (rxd_s) begin
              rbuffer_d = shreg_q;
              rda_set   = 1'b1;
              state_d   = IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = BREAK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      BREAK: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new byte outranks a same-cycle buffer read.
    rda_d       = rda_set | (rda_q & ~rd_rxbuf);
    frame_err_d = ferr_set | (frame_err_q & ~rd_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      rbuffer_q   <= '0;
      rda_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      rbuffer_q   <= rbuffer_d;
      rda_q       <= rda_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rbuffer   = rbuffer_q;
  assign rda       = rda_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: serial frames at 16 ticks/bit against a
// byte-level model of the receive buffer, data-available and error flags.
module tb_spart_rx;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned STOP_TICK  = 152;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rxd;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rbuffer;
  logic       rda;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rbuf;
  logic       exp_rda;
  logic       exp_ferr;

  always #5 clk = ~clk;

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rxd       (rxd),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .rbuffer   (rbuffer),
    .rda       (rda),
    .frame_err (frame_err)
  );

  // Baud tick: one clk wide every TICK_DIV clocks, changed mid-cycle.
  initial begin : tick_gen
    int div;
    div    = 0;
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      div    = (div + 1) % TICK_DIV;
      enable = (div == 0);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: what the bus should see after each completed frame or read.
  function automatic void model_frame(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) begin
      exp_rbuf = data;
      exp_rda  = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endfunction

  function automatic void model_read(input logic [1:0] addr);
    if (addr == 2'b00) exp_rda = 1'b0;
    if (addr == 2'b01) exp_ferr = 1'b0;
  endfunction

  function automatic void model_reset();
    exp_rbuf = 8'h00;
    exp_rda  = 1'b0;
    exp_ferr = 1'b0;
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (enable) k++;
    end
    #1;
  endtask

  task automatic bus_access(input logic rw, input logic [1:0] addr);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = rw; ioaddr = addr;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    if (rw) model_read(addr);
  endtask

  // Drives one frame; ticks are counted from the clock edge that leaves IDLE.
  task automatic run_frame(input logic [7:0] data, input logic stop_bit,
                           input int clr_tick, input int rst_tick,
                           output int rise_tick);
    int t;
    int j;
    logic prev_rda;
    rise_tick = -1;
    @(posedge clk); #1;
    rxd = 1'b0;
    prev_rda = rda;
    repeat (3) @(posedge clk);
    t = 0;
    while (t < 160) begin
      @(posedge clk);
      if (enable) begin
        t++;
        #1;
        if (t == clr_tick) begin
          iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        end
        if (rise_tick < 0 && rda === 1'b1 && prev_rda === 1'b0) rise_tick = t;
        prev_rda = rda;
        if (t == rst_tick) begin
          rst_n = 1'b0;
          rxd   = 1'b1;
          return;
        end
        if (t % 16 == 0) begin
          j = t / 16;
          if (j >= 1 && j <= 8) rxd = data[j-1];
          else if (j == 9) rxd = stop_bit;
          else if (j == 10 && stop_bit) rxd = 1'b1;
        end
        if (clr_tick > 0 && t == clr_tick - 1) begin
          repeat (TICK_DIV - 1) @(posedge clk);
          #1;
          iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        end
      end
    end
    if (clr_tick > 0) model_read(2'b00);
    model_frame(data, stop_bit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rbuffer !== 8'h00) begin errors++; $display("FAIL reset_rbuffer: got %h expected 00", rbuffer); end
    checks++;
    if (rda !== 1'b0) begin errors++; $display("FAIL reset_rda: got %b expected 0", rda); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    wait_ticks(8);
    checks++;
    if (rda !== 1'b0) begin errors++; $display("FAIL idle_rda: got %b expected 0", rda); end
  endtask

  task automatic test_single_byte();
    int rise;
    run_frame(8'hA5, 1'b1, -1, -1, rise);
    checks++;
    if (rise !== int'(STOP_TICK)) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rise, STOP_TICK); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL single_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL single_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL single_frame_err: got %b expected %b", frame_err, exp_ferr); end
  endtask

  task automatic test_read_clear();
    bus_access(1'b0, 2'b00);
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL write_no_effect: got %b expected %b", rda, exp_rda); end
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
    checks++;
    if (rda !== 1'b1) begin errors++; $display("FAIL read_before_edge: got %b expected 1", rda); end
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
    model_read(2'b00);
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL read_clear_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL read_clear_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
  endtask

  task automatic test_start_glitch();
    int rise;
    int len;
    len = int'($urandom_range(1, 5));
    @(posedge clk); #1;
    rxd = 1'b0;
    wait_ticks(len);
    rxd = 1'b1;
    wait_ticks(24);
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL glitch_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL glitch_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    run_frame(8'h3C, 1'b1, -1, -1, rise);
    checks++;
    if (rise !== int'(STOP_TICK)) begin errors++; $display("FAIL glitch_next_latency: got %0d expected %0d", rise, STOP_TICK); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL glitch_next_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
  endtask

  task automatic test_framing_error();
    int rise;
    bus_access(1'b1, 2'b00);
    run_frame(8'h5A, 1'b0, -1, -1, rise);
    wait_ticks(40);
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_set: got %b expected %b", frame_err, exp_ferr); end
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL ferr_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL ferr_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    rxd = 1'b1;
    wait_ticks(20);
    run_frame(8'h11, 1'b1, -1, -1, rise);
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL ferr_next_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    checks++;
    if (rise !== int'(STOP_TICK)) begin errors++; $display("FAIL ferr_next_latency: got %0d expected %0d", rise, STOP_TICK); end
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_sticky: got %b expected %b", frame_err, exp_ferr); end
    bus_access(1'b1, 2'b01);
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_status_clear: got %b expected %b", frame_err, exp_ferr); end
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL status_read_rda: got %b expected %b", rda, exp_rda); end
  endtask

  task automatic test_overrun();
    int rise;
    run_frame(8'h01, 1'b1, -1, -1, rise);
    run_frame(8'h02, 1'b1, -1, -1, rise);
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL overrun_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL overrun_rda: got %b expected %b", rda, exp_rda); end
    run_frame(8'h03, 1'b1, int'(STOP_TICK), -1, rise);
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL collision_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL collision_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
  endtask

  task automatic test_random_frames();
    int rise;
    logic [7:0] data;
    logic stop_bit;
    logic start_rda;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) bus_access(1'b1, 2'b00);
      if ($urandom_range(0, 3) == 0) bus_access(1'b1, 2'b01);
      data      = 8'($urandom);
      stop_bit  = ($urandom_range(0, 4) != 0);
      start_rda = exp_rda;
      run_frame(data, stop_bit, -1, -1, rise);
      if (!stop_bit) begin
        rxd = 1'b1;
        wait_ticks(20);
      end
      checks++;
      if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL rand%0d_rbuffer: got %h expected %h", n, rbuffer, exp_rbuf); end
      checks++;
      if (rda !== exp_rda) begin errors++; $display("FAIL rand%0d_rda: got %b expected %b", n, rda, exp_rda); end
      checks++;
      if (frame_err !== exp_ferr) begin errors++; $display("FAIL rand%0d_frame_err: got %b expected %b", n, frame_err, exp_ferr); end
      if (stop_bit && !start_rda) begin
        checks++;
        if (rise !== int'(STOP_TICK)) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, rise, STOP_TICK); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int rise;
    run_frame(8'h96, 1'b0, -1, -1, rise);
    rxd = 1'b1;
    wait_ticks(20);
    run_frame(8'hC3, 1'b1, -1, 84, rise);
    #1;
    model_reset();
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL midrst_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    checks++;
    if (rda !== exp_rda) begin errors++; $display("FAIL midrst_rda: got %b expected %b", rda, exp_rda); end
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL midrst_frame_err: got %b expected %b", frame_err, exp_ferr); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(4);
    run_frame(8'hFF, 1'b1, -1, -1, rise);
    checks++;
    if (rbuffer !== exp_rbuf) begin errors++; $display("FAIL postrst_rbuffer: got %h expected %h", rbuffer, exp_rbuf); end
    checks++;
    if (rise !== int'(STOP_TICK)) begin errors++; $display("FAIL postrst_latency: got %0d expected %0d", rise, STOP_TICK); end
    checks++;
    if (frame_err !== exp_ferr) begin errors++; $display("FAIL postrst_frame_err: got %b expected %b", frame_err, exp_ferr); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_read_clear();
    test_start_glitch();
    test_framing_error();
    test_overrun();
    test_random_frames();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
